interrupt_controller: RTL and testbench

- Sits directly upstream of the control unit and produces its `intr` input.
- Latches disk-completion, input-request and quantum-timer events, and tracks user/kernel execution mode from the control unit's `userMode`/`kernelMode` strobes.
- Raises `intr` only in user mode. On the control unit's `inta` it captures the interrupted PC and an interrupt code; the kernel reads these through gic/gip and releases them with `clearIntr` (cic).

---
 rtl/interrupt_pkg.sv | 31 +++
 rtl/interrupt_controller_quantum_timer.sv | 41 ++++
 rtl/interrupt_controller.sv | 117 +++++++++++
 tb/tb_interrupt_controller.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/interrupt_pkg.sv
// Shared interrupt codes and capture priority for the interrupt controller.
package interrupt_pkg;

    localparam int CODE_W  = 2;
    localparam int NUM_SRC = 3;

    typedef logic [CODE_W-1:0] int_code_t;

    localparam int_code_t INT_NONE  = 2'd0;
    localparam int_code_t INT_TIMER = 2'd1;
    localparam int_code_t INT_DISK  = 2'd2;
    localparam int_code_t INT_INPUT = 2'd3;

    // Highest index is highest priority: DISK > INPUT > TIMER.
    localparam logic [NUM_SRC-1:0][CODE_W-1:0] PRIO_ORDER = {INT_DISK, INT_INPUT, INT_TIMER};

    // Pending vector is indexed by code; bit 0 (NONE) is never set.
    function automatic int_code_t pick_code(input logic [(1<<CODE_W)-1:0] pend);
        int_code_t code;
        code = INT_NONE;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if ((code == INT_NONE) && pend[PRIO_ORDER[i]]) begin
                code = PRIO_ORDER[i];
            end else begin
                code = code;
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/interrupt_controller_quantum_timer.sv
// User-mode time-slice counter; pulses expire_o on the cycle it wraps from QUANTUM-1.
module quantum_timer #(
    parameter int QUANTUM   = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(QUANTUM - 1);
    localparam logic [CNT_WIDTH-1:0] ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    assign expire_o = en_i && !clr_i && (cnt_q == LAST);

    // Clear dominates; otherwise count and wrap at the end of the slice.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (en_i) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Latches disk/input/timer events, tracks user/kernel mode and runs the intr/inta capture handshake.
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int PC_WIDTH  = 32,
    parameter int QUANTUM   = 1024,
    parameter int CNT_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpuEn,
    input  logic                userMode,
    input  logic                kernelMode,
    input  logic                inta,
    input  logic                clearIntr,
    input  logic                diskDone,
    input  logic                inputReq,
    input  logic [PC_WIDTH-1:0] pc,
    output logic                intr,
    output logic [31:0]         intCode,
    output logic [PC_WIDTH-1:0] intPc,
    output logic                isUser
);

    localparam logic [0:0] ST_KERNEL = 1'b0;
    localparam logic [0:0] ST_USER   = 1'b1;
    localparam int         PEND_W    = 1 << CODE_W;

    logic [0:0]          mode_q, mode_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                intr_q, intr_d;
    int_code_t           code_q, code_d;
    logic [PC_WIDTH-1:0] int_pc_q, int_pc_d;
    logic                inp_q;

    logic                is_user_s, capture_s, expire_s, inp_rise_s;
    int_code_t           cap_code_s;
    logic [PEND_W-1:0]   set_mask_s, clr_mask_s;

    assign is_user_s  = (mode_q == ST_USER);
    assign capture_s  = cpuEn && intr_q && inta;
    assign cap_code_s = pick_code(pend_q);
    assign inp_rise_s = inputReq && !inp_q;

    quantum_timer #(
        .QUANTUM   (QUANTUM),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_quantum_timer (
        .clk_i    (clk),
        .rst_ni   (rst),
        .en_i     (cpuEn && is_user_s),
        .clr_i    (cpuEn && (userMode || (inta && !intr_q))),
        .expire_o (expire_s)
    );

    // Disk and input events latch even while halted; a new event beats a same-cycle clear.
    always_comb begin
        set_mask_s = {inp_rise_s, diskDone, expire_s, 1'b0};
        clr_mask_s = capture_s ? (PEND_W'(1) << cap_code_s) : {PEND_W{1'b0}};
        pend_d     = (pend_q & ~clr_mask_s) | set_mask_s;
    end

    // Mode FSM: kernelMode beats userMode, and a capture always drops to kernel.
    always_comb begin
        mode_d = mode_q;
        case (mode_q)
            ST_KERNEL: mode_d = (cpuEn && userMode && !kernelMode) ? ST_USER : ST_KERNEL;
            ST_USER:   mode_d = (cpuEn && (kernelMode || capture_s)) ? ST_KERNEL : ST_USER;
            default:   mode_d = ST_KERNEL;
        endcase
    end

    // Request/capture path; capture wins over a coincident clearIntr.
    always_comb begin
        intr_d   = intr_q;
        code_d   = code_q;
        int_pc_d = int_pc_q;
        if (cpuEn) begin
            intr_d = is_user_s && (|pend_q) && (code_q == INT_NONE) && !capture_s;
            if (capture_s) begin
                code_d   = cap_code_s;
                int_pc_d = pc;
            end else if (clearIntr) begin
                code_d   = INT_NONE;
            end else begin
                code_d   = code_q;
            end
        end else begin
            intr_d = intr_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q   <= ST_KERNEL;
            pend_q   <= {PEND_W{1'b0}};
            intr_q   <= 1'b0;
            code_q   <= INT_NONE;
            int_pc_q <= {PC_WIDTH{1'b0}};
            inp_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            intr_q   <= intr_d;
            code_q   <= code_d;
            int_pc_q <= int_pc_d;
            inp_q    <= inputReq;
        end
    end

    assign intr    = intr_q;
    assign intCode = {{(32-CODE_W){1'b0}}, code_q};
    assign intPc   = int_pc_q;
    assign isUser  = is_user_s;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed vector bench for interrupt_controller with QUANTUM=4.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpuEn = 1'b0, userMode = 1'b0, kernelMode = 1'b0, inta = 1'b0;
    logic        clearIntr = 1'b0, diskDone = 1'b0, inputReq = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        intr;
    logic [31:0] intCode;
    logic [31:0] intPc;
    logic        isUser;

    int applied = 0;
    int miscompares = 0;

    // Control bits: {cpuEn, userMode, kernelMode, inta, clearIntr, diskDone, inputReq}
    localparam logic [6:0] EN = 7'b1000000;
    localparam logic [6:0] UM = 7'b0100000;
    localparam logic [6:0] KM = 7'b0010000;
    localparam logic [6:0] IA = 7'b0001000;
    localparam logic [6:0] CI = 7'b0000100;
    localparam logic [6:0] DD = 7'b0000010;
    localparam logic [6:0] IR = 7'b0000001;

    typedef struct {
        logic [6:0]  ctl;
        logic [31:0] pc;
        logic        e_intr;
        logic [31:0] e_code;
        logic [31:0] e_pc;
        logic        e_user;
    } vec_t;

    vec_t vq[$];

    interrupt_controller #(.PC_WIDTH(32), .QUANTUM(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cpuEn(cpuEn), .userMode(userMode), .kernelMode(kernelMode),
        .inta(inta), .clearIntr(clearIntr), .diskDone(diskDone), .inputReq(inputReq),
        .pc(pc), .intr(intr), .intCode(intCode), .intPc(intPc), .isUser(isUser)
    );

    always #5 clk = ~clk;

    task automatic add(input logic [6:0] ctl, input logic [31:0] p, input logic ei,
                       input logic [31:0] ec, input logic [31:0] ep, input logic eu);
        vec_t v;
        v.ctl = ctl; v.pc = p; v.e_intr = ei; v.e_code = ec; v.e_pc = ep; v.e_user = eu;
        vq.push_back(v);
    endtask

    task automatic chk(input string nm, input logic ei, input logic [31:0] ec,
                       input logic [31:0] ep, input logic eu);
        applied++;
        if (intr !== ei || intCode !== ec || intPc !== ep || isUser !== eu) begin
            miscompares++;
            $display("FAIL %s: got intr=%0b code=%0d pc=%h user=%0b, want intr=%0b code=%0d pc=%h user=%0b",
                     nm, intr, intCode, intPc, isUser, ei, ec, ep, eu);
        end
    endtask

    task automatic drive(input logic [6:0] ctl, input logic [31:0] p);
        {cpuEn, userMode, kernelMode, inta, clearIntr, diskDone, inputReq} = ctl;
        pc = p;
    endtask

    initial begin
        // Timer expiry and capture
        add(EN|UM, 32'h0,  1'b0, 32'd0, 32'h0,  1'b1);
        add(EN,    32'h0,  1'b0, 32'd0, 32'h0,  1'b1);
        add(EN,    32'h0,  1'b0, 32'd0, 32'h0,  1'b1);
        add(EN,    32'h0,  1'b0, 32'd0, 32'h0,  1'b1);
        add(EN,    32'h0,  1'b0, 32'd0, 32'h0,  1'b1);
        add(EN,    32'h0,  1'b1, 32'd0, 32'h0,  1'b1);
        add(EN|IA, 32'h20, 1'b0, 32'd1, 32'h20, 1'b0);
        add(EN|CI, 32'h0,  1'b0, 32'd0, 32'h20, 1'b0);
        // Disk and input together: disk first, then input
        add(EN|UM,       32'h0,  1'b0, 32'd0, 32'h20, 1'b1);
        add(EN|DD|IR,    32'h0,  1'b0, 32'd0, 32'h20, 1'b1);
        add(EN|IR,       32'h0,  1'b1, 32'd0, 32'h20, 1'b1);
        add(EN|IA|IR,    32'h44, 1'b0, 32'd2, 32'h44, 1'b0);
        add(EN|CI,       32'h0,  1'b0, 32'd0, 32'h44, 1'b0);
        add(EN|UM,       32'h0,  1'b0, 32'd0, 32'h44, 1'b1);
        add(EN,          32'h0,  1'b1, 32'd0, 32'h44, 1'b1);
        add(EN|IA,       32'h48, 1'b0, 32'd3, 32'h48, 1'b0);
        add(EN|CI,       32'h0,  1'b0, 32'd0, 32'h48, 1'b0);
        // Disk event in kernel mode waits for user mode
        add(EN|DD,       32'h0,  1'b0, 32'd0, 32'h48, 1'b0);
        add(EN,          32'h0,  1'b0, 32'd0, 32'h48, 1'b0);
        add(EN|UM,       32'h0,  1'b0, 32'd0, 32'h48, 1'b1);
        add(EN,          32'h0,  1'b1, 32'd0, 32'h48, 1'b1);
        add(EN|IA,       32'h60, 1'b0, 32'd2, 32'h60, 1'b0);
        // Uncleared code blocks intr while the timer expires
        add(EN|UM,       32'h0,  1'b0, 32'd2, 32'h60, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd2, 32'h60, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd2, 32'h60, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd2, 32'h60, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd2, 32'h60, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd2, 32'h60, 1'b1);
        add(EN|CI,       32'h0,  1'b0, 32'd0, 32'h60, 1'b1);
        add(EN,          32'h0,  1'b1, 32'd0, 32'h60, 1'b1);
        // Capture coincides with a new timer expiry: pending timer survives
        add(EN|IA,       32'h70, 1'b0, 32'd1, 32'h70, 1'b0);
        add(EN|CI,       32'h0,  1'b0, 32'd0, 32'h70, 1'b0);
        add(EN|UM,       32'h0,  1'b0, 32'd0, 32'h70, 1'b1);
        add(EN,          32'h0,  1'b1, 32'd0, 32'h70, 1'b1);
        add(EN|KM,       32'h0,  1'b1, 32'd0, 32'h70, 1'b0);
        add(EN,          32'h0,  1'b0, 32'd0, 32'h70, 1'b0);
        add(EN|UM,       32'h0,  1'b0, 32'd0, 32'h70, 1'b1);
        add(EN,          32'h0,  1'b1, 32'd0, 32'h70, 1'b1);
        add(EN|IA,       32'h80, 1'b0, 32'd1, 32'h80, 1'b0);
        add(EN|CI,       32'h0,  1'b0, 32'd0, 32'h80, 1'b0);
        // pre_io inta at count 3 restarts the slice
        add(EN|UM,       32'h0,  1'b0, 32'd0, 32'h80, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd0, 32'h80, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd0, 32'h80, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd0, 32'h80, 1'b1);
        add(EN|IA,       32'h0,  1'b0, 32'd0, 32'h80, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd0, 32'h80, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd0, 32'h80, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd0, 32'h80, 1'b1);
        add(EN,          32'h0,  1'b0, 32'd0, 32'h80, 1'b1);
        add(EN,          32'h0,  1'b1, 32'd0, 32'h80, 1'b1);
        add(EN|IA,       32'h90, 1'b0, 32'd1, 32'h90, 1'b0);
        add(EN|CI,       32'h0,  1'b0, 32'd0, 32'h90, 1'b0);
        // cpuEn=0 freezes state but still latches events
        add(EN|UM,       32'h0,  1'b0, 32'd0, 32'h90, 1'b1);
        add(DD,          32'h0,  1'b0, 32'd0, 32'h90, 1'b1);
        add(KM,          32'h0,  1'b0, 32'd0, 32'h90, 1'b1);
        add(EN,          32'h0,  1'b1, 32'd0, 32'h90, 1'b1);
        add(IA,          32'hA0, 1'b1, 32'd0, 32'h90, 1'b1);
        add(EN|IA|CI,    32'hA4, 1'b0, 32'd2, 32'hA4, 1'b0);
        add(EN|CI,       32'h0,  1'b0, 32'd0, 32'hA4, 1'b0);
        add(IR,          32'h0,  1'b0, 32'd0, 32'hA4, 1'b0);
        add(EN|UM|IR,    32'h0,  1'b0, 32'd0, 32'hA4, 1'b1);
        add(EN|IR,       32'h0,  1'b1, 32'd0, 32'hA4, 1'b1);
        add(EN|IA,       32'hB0, 1'b0, 32'd3, 32'hB0, 1'b0);
        // Both mode strobes: kernel wins
        add(EN|UM|KM,    32'h0,  1'b0, 32'd3, 32'hB0, 1'b0);
        add(EN|CI,       32'h0,  1'b0, 32'd0, 32'hB0, 1'b0);
        add(EN|DD,       32'h0,  1'b0, 32'd0, 32'hB0, 1'b0);
        add(EN|UM,       32'h0,  1'b0, 32'd0, 32'hB0, 1'b1);
        add(EN,          32'h0,  1'b1, 32'd0, 32'hB0, 1'b1);

        drive(7'b0000000, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 1'b0, 32'd0, 32'h0, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].ctl, vq[i].pc);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), vq[i].e_intr, vq[i].e_code, vq[i].e_pc, vq[i].e_user);
        end

        // Asynchronous reset while intr is high, checked before any clock edge
        drive(EN, 32'h0);
        #3;
        rst = 1'b0;
        #1;
        chk("async_reset", 1'b0, 32'd0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        chk("reset_hold", 1'b0, 32'd0, 32'h0, 1'b0);
        rst = 1'b1;

        // Pending disk event was discarded by the reset
        drive(EN|UM, 32'h0);
        @(posedge clk);
        #1;
        chk("post_reset_um", 1'b0, 32'd0, 32'h0, 1'b1);
        drive(EN, 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("post_reset_idle", 1'b0, 32'd0, 32'h0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
